// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants and helpers for the synchronous up/down counter family.
//   MODE_WRAP / MODE_SAT : legal values of the SATURATE parameter.
//   clamp_load()         : limits a parallel-load value to the largest legal
//                          count state (MODULUS-1).
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Operates on 32-bit values so it can serve every legal WIDTH (1..32);
  // callers zero-extend into it and truncate the result back to WIDTH.
  function automatic logic [31:0] clamp_load(input logic [31:0] load_val,
                                             input logic [31:0] max_val);
    return (load_val > max_val) ? max_val : load_val;
  endfunction

endpackage

// File: rtl/counter_next.sv
// -----------------------------------------------------------------------------
// counter_next
// Purely combinational next-state logic for sync_updown_counter.
// Ports:
//   count      in  current registered count
//   up         in  1 = increment, 0 = decrement
//   en         in  count enable
//   load       in  parallel load (has priority over en)
//   load_val   in  value to load (clamped to MODULUS-1)
//   next_count out count value for the next edge (reset not applied here)
//   wrap_evt   out this edge wraps past a limit
//   tc         out terminal count, for cascading into a higher stage
// -----------------------------------------------------------------------------
module counter_next
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [31:0]      MAX32 = 32'(MODULUS - 1);

  logic at_max;
  logic at_zero;

  assign at_max  = (count == MAX);
  assign at_zero = (count == '0);

  always_comb begin
    next_count = count;
    wrap_evt   = 1'b0;
    if (load) begin
      next_count = WIDTH'(clamp_load(32'(load_val), MAX32));
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          next_count = count + 1'b1;
        end else if (SATURATE == MODE_WRAP) begin
          // Wrap to zero rather than to 2**WIDTH so non power-of-two moduli work.
          next_count = '0;
          wrap_evt   = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          next_count = count - 1'b1;
        end else if (SATURATE == MODE_WRAP) begin
          next_count = MAX;
          wrap_evt   = 1'b1;
        end
      end
    end
  end

  // Independent of load and saturation so a cascaded stage sees a clean
  // zero-latency carry/borrow.
  assign tc = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: rtl/sync_updown_counter.sv
// -----------------------------------------------------------------------------
// sync_updown_counter
// Parametrised synchronous up/down counter with modulus, parallel load,
// enable and wrap/saturate mode. Cascade by tying the next stage's EN to TC.
// Ports:
//   CLK       in  clock, all state updates on the rising edge
//   RESET     in  synchronous active-high reset
//   EN        in  count enable
//   UP        in  direction (1 = up, 0 = down)
//   LOAD      in  synchronous parallel load (priority over EN)
//   LOAD_VAL  in  load value, clamped to MODULUS-1
//   COUNT     out registered count
//   TC        out combinational terminal count
//   WRAP      out registered one-cycle pulse after a wrap
//   AT_LIMIT  out registered: COUNT is at the limit for the current direction
// -----------------------------------------------------------------------------
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     SATURATE = MODE_WRAP
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             WRAP,
  output logic             AT_LIMIT
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_updown_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("sync_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("sync_updown_counter: SATURATE must be 0 or 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_limit_q, at_limit_d;
  logic [WIDTH-1:0] next_count;
  logic             wrap_evt;
  logic             tc;

  counter_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (count_q),
    .up         (UP),
    .en         (EN),
    .load       (LOAD),
    .load_val   (LOAD_VAL),
    .next_count (next_count),
    .wrap_evt   (wrap_evt),
    .tc         (tc)
  );

  always_comb begin
    count_d    = next_count;
    wrap_d     = wrap_evt;
    // Limit flag looks ahead at the value COUNT is about to take.
    at_limit_d = UP ? (next_count == MAX) : (next_count == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      at_limit_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign COUNT    = count_q;
  assign WRAP     = wrap_q;
  assign AT_LIMIT = at_limit_q;
  assign TC       = tc;

endmodule

// File: tb/tb_sync_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_sync_updown_counter
// Drives four configurations from one stimulus stream: MODULUS=10 wrapping,
// MODULUS=16 saturating, WIDTH=1 MODULUS=2 wrapping, and a two-stage
// MODULUS=10 cascade. Expected values come from an arithmetic reference model
// and are queued; independent monitors pop and compare.
// -----------------------------------------------------------------------------
module tb_sync_updown_counter;

  logic       clk;
  logic       rst;
  logic       ld;
  logic       en;
  logic       up;
  logic [3:0] lv;

  logic [3:0] cnt_w, cnt_s, lo_cnt, hi_cnt;
  logic [0:0] cnt_m;
  logic       tc_w, wr_w, al_w;
  logic       tc_s, wr_s, al_s;
  logic       tc_m, wr_m, al_m;
  logic       tc_lo, wr_lo, al_lo;
  logic       tc_hi, wr_hi, al_hi;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
    .CLK(clk), .RESET(rst), .EN(en), .UP(up), .LOAD(ld), .LOAD_VAL(lv),
    .COUNT(cnt_w), .TC(tc_w), .WRAP(wr_w), .AT_LIMIT(al_w)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1)) u_sat (
    .CLK(clk), .RESET(rst), .EN(en), .UP(up), .LOAD(ld), .LOAD_VAL(lv),
    .COUNT(cnt_s), .TC(tc_s), .WRAP(wr_s), .AT_LIMIT(al_s)
  );

  sync_updown_counter #(.WIDTH(1), .MODULUS(2), .SATURATE(0)) u_m2 (
    .CLK(clk), .RESET(rst), .EN(en), .UP(up), .LOAD(ld), .LOAD_VAL(lv[0]),
    .COUNT(cnt_m), .TC(tc_m), .WRAP(wr_m), .AT_LIMIT(al_m)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
    .CLK(clk), .RESET(rst), .EN(en), .UP(up), .LOAD(1'b0), .LOAD_VAL(4'd0),
    .COUNT(lo_cnt), .TC(tc_lo), .WRAP(wr_lo), .AT_LIMIT(al_lo)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
    .CLK(clk), .RESET(rst), .EN(tc_lo), .UP(up), .LOAD(1'b0), .LOAD_VAL(4'd0),
    .COUNT(hi_cnt), .TC(tc_hi), .WRAP(wr_hi), .AT_LIMIT(al_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int cnt_w; bit wr_w; bit al_w;
    int cnt_s; bit wr_s; bit al_s;
    int cnt_m; bit wr_m; bit al_m;
    int v;     bit wr_lo; bit wr_hi; bit al_lo; bit al_hi;
  } exp_t;

  typedef struct {
    bit w; bit s; bit m; bit lo; bit hi;
  } tc_t;

  exp_t exp_q[$];
  tc_t  tc_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: plain integer counts; cascade held as one 0..99 value.
  int mw = 0;
  int ms = 0;
  int mm = 0;
  int mv = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One edge of a MODULUS-m counter: modular step, with saturation at the ends.
  function automatic int model_next(input int m, input bit sat, input int c,
                                    input bit l, input bit e, input bit u,
                                    input int lvv, output bit w);
    int  n;
    bit  at_edge;
    w = 1'b0;
    n = c;
    if (l) begin
      n = (lvv > m - 1) ? m - 1 : lvv;
    end else if (e) begin
      at_edge = u ? (c == m - 1) : (c == 0);
      if (!(at_edge && sat)) begin
        n = u ? (c + 1) % m : (c + m - 1) % m;
        w = at_edge;
      end
    end
    return n;
  endfunction

  task automatic cycle(input bit r, input bit l, input bit e, input bit u, input int lvv);
    exp_t x;
    tc_t  t;
    @(posedge clk);
    #2;
    rst = r; ld = l; en = e; up = u; lv = 4'(lvv);
    t.w  = e && (u ? (mw == 9)  : (mw == 0));
    t.s  = e && (u ? (ms == 15) : (ms == 0));
    t.m  = e && (u ? (mm == 1)  : (mm == 0));
    t.lo = e && (u ? (mv % 10 == 9) : (mv % 10 == 0));
    t.hi = e && (u ? (mv == 99) : (mv == 0));
    tc_q.push_back(t);
    x = '{default: 0};
    if (r) begin
      mw = 0; ms = 0; mm = 0; mv = 0;
    end else begin
      mw = model_next(10, 1'b0, mw, l, e, u, lvv, x.wr_w);
      ms = model_next(16, 1'b1, ms, l, e, u, lvv, x.wr_s);
      mm = model_next(2,  1'b0, mm, l, e, u, lvv % 2, x.wr_m);
      if (e) mv = u ? (mv + 1) % 100 : (mv + 99) % 100;
      x.al_w  = u ? (mw == 9)  : (mw == 0);
      x.al_s  = u ? (ms == 15) : (ms == 0);
      x.al_m  = u ? (mm == 1)  : (mm == 0);
      x.wr_lo = t.lo;
      x.wr_hi = t.hi;
      x.al_lo = u ? (mv % 10 == 9) : (mv % 10 == 0);
      x.al_hi = u ? (mv / 10 == 9) : (mv / 10 == 0);
    end
    x.cnt_w = mw; x.cnt_s = ms; x.cnt_m = mm; x.v = mv;
    exp_q.push_back(x);
    $display("cyc t=%0t rst=%0d ld=%0d en=%0d up=%0d lv=%0d -> exp w=%0d s=%0d m=%0d casc=%0d",
             $time, r, l, e, u, lvv, mw, ms, mm, mv);
  endtask

  // Registered outputs: checked 1 time unit after each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count_wrap",   int'(cnt_w), x.cnt_w);
        chk("wrap_wrap",    int'(wr_w),  int'(x.wr_w));
        chk("limit_wrap",   int'(al_w),  int'(x.al_w));
        chk("count_sat",    int'(cnt_s), x.cnt_s);
        chk("wrap_sat",     int'(wr_s),  int'(x.wr_s));
        chk("limit_sat",    int'(al_s),  int'(x.al_s));
        chk("count_m2",     int'(cnt_m), x.cnt_m);
        chk("wrap_m2",      int'(wr_m),  int'(x.wr_m));
        chk("limit_m2",     int'(al_m),  int'(x.al_m));
        chk("count_casc",   int'(hi_cnt) * 10 + int'(lo_cnt), x.v);
        chk("wrap_lo",      int'(wr_lo), int'(x.wr_lo));
        chk("wrap_hi",      int'(wr_hi), int'(x.wr_hi));
        chk("limit_lo",     int'(al_lo), int'(x.al_lo));
        chk("limit_hi",     int'(al_hi), int'(x.al_hi));
      end
    end
  end

  // Combinational TC: checked mid-cycle after inputs have settled.
  initial begin
    tc_t t;
    forever begin
      @(negedge clk);
      if (tc_q.size() > 0) begin
        t = tc_q.pop_front();
        chk("tc_wrap", int'(tc_w),  int'(t.w));
        chk("tc_sat",  int'(tc_s),  int'(t.s));
        chk("tc_m2",   int'(tc_m),  int'(t.m));
        chk("tc_lo",   int'(tc_lo), int'(t.lo));
        chk("tc_hi",   int'(tc_hi), int'(t.hi));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ld = 1'b0; en = 1'b0; up = 1'b1; lv = 4'd0;

    // Reset, including two edges with EN high, then count 1,2,3.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 0);
    repeat (2) cycle(1'b1, 1'b0, 1'b1, 1'b1, 0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1, 0);

    // Up wrap from 0 over ten edges.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 0);
    repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b1, 0);

    // Load 2, count down through 0 with wrap, then clamped load beating EN.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 2);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 15);

    // Saturation from 14 upward, then reverse.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 14);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Cascade: full 00..99..00 sweep from reset.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 0);
    repeat (101) cycle(1'b0, 1'b0, 1'b1, 1'b1, 0);

    // Reset arriving while LOAD and EN are also asserted.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 7);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 7);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 7);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(39) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
            1'($urandom_range(1)), int'($urandom_range(15)));
    end

    repeat (3) @(posedge clk);
    #3;
    chk("queues_drained", exp_q.size() + tc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
